// File: rtl/carry_counter_sequencer_pkg.sv
// Shared types and reset defaults for the carry counter sequencer.
package carry_counter_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Per-bit fill values: terminal value resets to all ones, prescale to zero.
    localparam logic DEF_PERIOD_BIT   = 1'b1;
    localparam logic DEF_PRESCALE_BIT = 1'b0;
    localparam logic DEF_AUTO         = 1'b1;

endpackage

// File: rtl/carry_counter_sequencer_core.sv
// Synchronous series-carry counter: bit i toggles when enabled and all lower bits are 1.
module carry_chain_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] toggle;
    logic             carry;

    always_comb begin
        toggle = '0;
        carry  = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            toggle[i] = carry;
            carry     = carry & q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ toggle;
        end
    end

endmodule

// File: rtl/carry_counter_sequencer.sv
// Run/stop/resume/clear sequencer around a series-carry counter with prescaler and terminal count.
module carry_counter_sequencer
    import carry_counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [PS_W-1:0]  cfg_prescale,
    input  logic             cfg_auto,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             tc,
    output logic             cfg_err
);

    state_t           state, state_n;
    logic             done, done_n;
    logic [PS_W-1:0]  presc, presc_n;
    logic [WIDTH-1:0] period;
    logic [PS_W-1:0]  prescale;
    logic             auto_mode;

    logic             core_en, core_sclr;
    logic             cfg_load;
    logic             tick_n, tc_n, err_n;
    logic [WIDTH-1:0] next_count;

    carry_chain_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (core_en),
        .sclr (core_sclr),
        .q    (count)
    );

    assign next_count = (count == period) ? '0 : count + WIDTH'(1);

    always_comb begin
        state_n   = state;
        done_n    = done;
        presc_n   = presc;
        core_en   = 1'b0;
        core_sclr = 1'b0;
        tick_n    = 1'b0;
        tc_n      = 1'b0;
        err_n     = 1'b0;
        cfg_load  = 1'b0;

        if (cfg_we && !clr) begin
            if (state == RUN) begin
                err_n = 1'b1;
            end else begin
                cfg_load = 1'b1;
            end
        end

        if (clr) begin
            state_n   = IDLE;
            done_n    = 1'b0;
            presc_n   = '0;
            core_sclr = 1'b1;
        end else if (stop && state == RUN) begin
            state_n = HALT;
            done_n  = 1'b0;
        end else if (start && state != RUN) begin
            // Fresh start from IDLE or after one-shot completion; a stopped HALT resumes as-is.
            if (state == IDLE || done) begin
                presc_n   = '0;
                core_sclr = 1'b1;
            end
            state_n = RUN;
            done_n  = 1'b0;
        end else if (state == RUN) begin
            if (presc == prescale) begin
                presc_n = '0;
                tick_n  = 1'b1;
                tc_n    = (next_count == period);
                if (count == period) begin
                    core_sclr = 1'b1;
                end else begin
                    core_en = 1'b1;
                end
                if (tc_n && !auto_mode) begin
                    state_n = HALT;
                    done_n  = 1'b1;
                end
            end else begin
                presc_n = presc + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            presc     <= '0;
            period    <= {WIDTH{DEF_PERIOD_BIT}};
            prescale  <= {PS_W{DEF_PRESCALE_BIT}};
            auto_mode <= DEF_AUTO;
            busy      <= 1'b0;
            tick      <= 1'b0;
            tc        <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= done_n;
            presc   <= presc_n;
            busy    <= (state_n == RUN);
            tick    <= tick_n;
            tc      <= tc_n;
            cfg_err <= err_n;
            if (cfg_load) begin
                period    <= cfg_period;
                prescale  <= cfg_prescale;
                auto_mode <= cfg_auto;
            end
        end
    end

endmodule

// File: tb/tb_carry_counter_sequencer.sv
// Scoreboard bench: randomized and directed control sequences checked against a behavioural model.
module tb_carry_counter_sequencer;

    localparam int WIDTH = 4;
    localparam int PS_W  = 4;

    logic             clk = 1'b0;
    logic             rst, cfg_we, cfg_auto, start, stop, clr;
    logic [WIDTH-1:0] cfg_period;
    logic [PS_W-1:0]  cfg_prescale;
    logic [WIDTH-1:0] count;
    logic             busy, tick, tc, cfg_err;

    carry_counter_sequencer #(
        .WIDTH(WIDTH),
        .PS_W (PS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_period  (cfg_period),
        .cfg_prescale(cfg_prescale),
        .cfg_auto    (cfg_auto),
        .start       (start),
        .stop        (stop),
        .clr         (clr),
        .count       (count),
        .busy        (busy),
        .tick        (tick),
        .tc          (tc),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit tick;
        bit tc;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: plain integers, counts modulo 2**WIDTH.
    int m_cnt, m_ph, m_p, m_ps;
    bit m_auto, m_running, m_halted, m_done;

    function automatic exp_t model_step(input bit r, s, sp, c, w, input int p, ps, input bit a);
        exp_t e;
        e.tick = 0;
        e.tc   = 0;
        e.err  = 0;
        if (r) begin
            m_cnt = 0; m_ph = 0; m_running = 0; m_halted = 0; m_done = 0;
            m_p = (1 << WIDTH) - 1; m_ps = 0; m_auto = 1;
        end else if (c) begin
            m_cnt = 0; m_ph = 0; m_running = 0; m_halted = 0; m_done = 0;
        end else begin
            if (w) begin
                if (m_running) e.err = 1;
                else begin m_p = p; m_ps = ps; m_auto = a; end
            end
            if (sp && m_running) begin
                m_running = 0; m_halted = 1; m_done = 0;
            end else if (s && !m_running) begin
                if (!m_halted || m_done) begin m_cnt = 0; m_ph = 0; end
                m_running = 1; m_halted = 0; m_done = 0;
            end else if (m_running) begin
                if (m_ph == m_ps) begin
                    m_ph   = 0;
                    m_cnt  = (m_cnt == m_p) ? 0 : (m_cnt + 1) % (1 << WIDTH);
                    e.tick = 1;
                    e.tc   = (m_cnt == m_p);
                    if (e.tc && !m_auto) begin
                        m_running = 0; m_halted = 1; m_done = 1;
                    end
                end else begin
                    m_ph = (m_ph + 1) % (1 << PS_W);
                end
            end
        end
        e.count = m_cnt;
        e.busy  = m_running;
        return e;
    endfunction

    task automatic cycle(input bit r, s, sp, c, w, input int p, ps, input bit a);
        exp_t e;
        rst = r; start = s; stop = sp; clr = c; cfg_we = w;
        cfg_period = WIDTH'(p); cfg_prescale = PS_W'(ps); cfg_auto = a;
        e = model_step(r, s, sp, c, w, p, ps, a);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("count",   int'(count),   e.count);
                check("busy",    int'(busy),    int'(e.busy));
                check("tick",    int'(tick),    int'(e.tick));
                check("tc",      int'(tc),      int'(e.tc));
                check("cfg_err", int'(cfg_err), int'(e.err));
            end
        end
    end

    initial begin : driver
        bit r, s, sp, c, w, a;
        int p, ps;
        rst = 1; start = 0; stop = 0; clr = 0; cfg_we = 0;
        cfg_period = '0; cfg_prescale = '0; cfg_auto = 0;

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Periodic P=5, PS=0
        cycle(0, 0, 0, 0, 1, 5, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(14);

        // One-shot P=3, PS=2 with config written alongside start
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 3, 2, 0);
        idle(12);

        // Stop mid-phase, hold, resume
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 7, 3, 1);
        idle(10);
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        idle(5);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(9);

        // stop+start together in RUN, then resume; cfg_we rejected in RUN
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        idle(2);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 2, 1, 0);
        idle(6);

        // P=0 one-shot, restart from done, clr mid-run
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0, 1, 0);
        idle(5);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(4);
        cycle(0, 0, 0, 0, 1, 9, 1, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Reset mid-run restores default config (P=15, PS=0, periodic)
        cycle(0, 1, 0, 0, 1, 9, 1, 0);
        idle(4);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(20);

        // Randomized control traffic
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 59) == 0);
            sp = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 7) == 0);
            w  = ($urandom_range(0, 9) == 0);
            p  = $urandom_range(0, 15);
            ps = $urandom_range(0, 3);
            a  = $urandom_range(0, 1);
            cycle(r, s, sp, c, w, p, ps, a);
        end
        idle(2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/carry_counter_sequencer.md
# carry_counter_sequencer

Run/stop controller for a WIDTH-bit synchronous series-carry counter. The block holds a programmable terminal value, an enable prescaler and a mode bit. It sequences the counter through start, stop, resume and clear, and flags each advance and each terminal count. Timers, sequencers and blinkers in the design instantiate it in place of a free-running counter.

## Interface
- WIDTH, 4: counter width.
- PS_W, 4: prescaler width.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write cfg_period/cfg_prescale/cfg_auto; accepted only when not busy
- cfg_period  in  WIDTH  terminal value P
- cfg_prescale  in  PS_W  advance every PS+1 clocks
- cfg_auto  in  1  1 = periodic (wrap), 0 = one-shot
- start  in  1  start or resume
- stop  in  1  halt, keeping count
- clr  in  1  return to IDLE, count 0
- count  out  WIDTH  counter value
- busy  out  1  high in RUN
- tick  out  1  1-cycle pulse, coincident with a new count value
- tc  out  1  1-cycle pulse, coincident with count becoming P
- cfg_err  out  1  1-cycle pulse: cfg_we rejected

## Operation
- States: IDLE, RUN, HALT. HALT carries a `done` flag: 1 = one-shot completed, 0 = stopped.
- Reset:
  - State IDLE, count 0, prescaler 0, done 0.
  - P = all ones, PS = 0, auto = 1.
  - All pulse outputs 0, busy 0.
- Priority per edge: rst > clr > stop > start > cfg_we.
- clr, any state: go to IDLE, count 0, prescaler 0, done 0. Config is kept.
- cfg_we outside RUN: config registers load.
  - cfg_we with start in IDLE: the new config governs the run.
- cfg_we in RUN: no change; cfg_err = 1 the next cycle.
- IDLE + start: count 0, prescaler 0, go to RUN.
- RUN:
  - Prescaler increments each cycle.
  - When it equals PS, it returns to 0 and an advance occurs.
- Advance:
  - next = (count == P) ? 0 : count + 1.
  - tick = 1.
  - tc = (next == P).
- Advance with tc and auto = 0: go to HALT with done = 1; count holds P.
- RUN + stop: go to HALT, done 0. Count and prescaler freeze; no advance that edge.
- HALT + start:
  - done = 0: resume RUN from the frozen count and prescaler.
  - done = 1: count 0, prescaler 0, RUN (restart).
- start in RUN and stop outside RUN: no effect.
- P = 0: every advance yields count 0 with tc = 1. One-shot halts on the first advance.
- Counter increment uses the series-carry form: bit i toggles when enabled and bits 0..i-1 are all 1.
- Wrap-to-0 and clear use the core's synchronous clear.

## Timing
- All outputs are registered.
- tick and tc are high for exactly the one cycle in which count shows the new value.
- busy = 1 exactly while the state is RUN.
  - busy falls in the same cycle that count shows P on one-shot completion.
- First advance: count changes at the (PS+1)th edge after the edge that sampled start.
  - PS = 0: count = 1 one cycle after busy rises.
- Steady state: one advance per PS+1 cycles.
- Periodic period: (P+1)·(PS+1) cycles per tc.
- Stop/resume is cycle-exact: stop at prescaler value k, resume continues from k.
- cfg_err rises one cycle after the offending cfg_we.

## Structure
- Package `carry_counter_sequencer_pkg`:
  - State enum {IDLE, RUN, HALT}.
  - Reset defaults for P, PS and auto.
- Sub-module `carry_chain_counter_core` (params WIDTH):
  - Inputs: clk, rst, en, sclr.
  - Output: q.
  - Implements the series-AND carry chain.
  - sclr has priority over en.
- The top level holds the FSM, prescaler, config registers and pulse generation.

## Test plan
- Reset, then P=5, PS=0, auto=1, start → count 0,1,2,3,4,5,0… one per cycle; tc with each 5; tick every cycle; busy = 1.
- P=3, PS=2, auto=0, start → advances every 3 cycles; count reaches 3 with tc at the 9th edge after start; busy falls the same cycle; count holds 3.
- Periodic run, stop at count 2 with prescaler mid-phase; hold 5 cycles; start → count frozen during the hold; the next advance comes at the remaining prescale phase.
- Same cycle stop+start in RUN → HALT (stop wins); cfg_we in RUN → no config change, cfg_err pulse next cycle.
- P=0 one-shot → one tc with count 0, then HALT; start from HALT (done) → restart; clr mid-run → count 0, IDLE, busy 0.
- rst asserted mid-RUN → next cycle count 0, IDLE, config back to P=all ones, PS=0, auto=1.
